// File: rtl/vend_pkg.sv
// Shared types and constants for the vending session arbiter.
// Coin codes match the vending core's coin port.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RESP
    } state_t;

    localparam logic [1:0] COIN_NONE   = 2'b00;
    localparam logic [1:0] COIN_5      = 2'b01;
    localparam logic [1:0] COIN_10     = 2'b10;
    localparam logic [1:0] COIN_CANCEL = 2'b11;

    localparam int PRICE_UNITS = 4;

endpackage

// File: rtl/vend_session_arbiter_rr_picker.sv
// Cyclic first-set search over kiosk requests, starting at ptr.
// Purely combinational; idx is only meaningful when hit is set.
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 hit,
    output logic [$clog2(N)-1:0] idx
);

    localparam int W = $clog2(N);

    logic [W:0] s;

    // Walk offsets downward so the closest set bit to ptr wins last.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        s   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            s = {1'b0, ptr} + (W + 1)'(k);
            if (s >= (W + 1)'(N)) begin
                s = s - (W + 1)'(N);
            end
            if (req[s[W-1:0]]) begin
                hit = 1'b1;
                idx = s[W-1:0];
            end
        end
    end

endmodule

// File: rtl/vend_session_arbiter.sv
// Round-robin session arbiter sharing one vending core among N kiosks.
// One owner at a time; session ends on drink, cancel or idle timeout.
module vend_session_arbiter
    import vend_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req_valid,
    input  logic [2*N-1:0]       req_coin,
    output logic [N-1:0]         req_ready,
    output logic [N-1:0]         gnt,
    output logic                 res_valid,
    output logic [$clog2(N)-1:0] res_id,
    output logic                 res_drink,
    output logic [1:0]           res_back,
    output logic                 res_end,
    output logic [1:0]           core_coin,
    input  logic                 core_drink,
    input  logic [1:0]           core_back
);

    localparam int W  = $clog2(N);
    localparam int CW = $clog2(TIMEOUT);

    state_t        state, state_nx;
    logic [W-1:0]  owner, owner_nx;
    logic [W-1:0]  rr_ptr, rr_ptr_nx;
    logic [W-1:0]  pick;
    logic [CW-1:0] idle_cnt, idle_cnt_nx;
    logic          cancel, cancel_nx;
    logic          hit;
    logic          own_valid;
    logic          sess_end;
    logic [1:0]    own_coin;

    rr_picker #(.N(N)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .hit (hit),
        .idx (pick)
    );

    assign own_coin  = req_coin[{owner, 1'b0} +: 2];
    assign own_valid = req_valid[owner];
    assign sess_end  = core_drink | cancel;

    always_comb begin
        gnt = '0;
        if (state != IDLE) begin
            gnt[owner] = 1'b1;
        end
    end

    always_comb begin
        state_nx    = state;
        owner_nx    = owner;
        rr_ptr_nx   = rr_ptr;
        idle_cnt_nx = idle_cnt;
        cancel_nx   = cancel;
        core_coin   = COIN_NONE;
        req_ready   = '0;
        unique case (state)
            IDLE: begin
                if (hit) begin
                    owner_nx    = pick;
                    idle_cnt_nx = '0;
                    state_nx    = XFER;
                end
            end
            XFER: begin
                if (own_valid) begin
                    core_coin        = own_coin;
                    req_ready[owner] = 1'b1;
                    cancel_nx        = (own_coin == COIN_CANCEL);
                    idle_cnt_nx      = '0;
                    state_nx         = RESP;
                end else if (idle_cnt == CW'(TIMEOUT - 1)) begin
                    // Abandoned session: force a cancel so the core refunds.
                    core_coin = COIN_CANCEL;
                    cancel_nx = 1'b1;
                    state_nx  = RESP;
                end else if (idle_cnt != '1) begin
                    idle_cnt_nx = idle_cnt + 1'b1;
                end
            end
            RESP: begin
                if (sess_end) begin
                    rr_ptr_nx = (owner == W'(N - 1)) ? '0 : owner + 1'b1;
                    state_nx  = IDLE;
                end else begin
                    state_nx = XFER;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            idle_cnt  <= '0;
            cancel    <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_drink <= 1'b0;
            res_back  <= '0;
            res_end   <= 1'b0;
        end else begin
            state    <= state_nx;
            owner    <= owner_nx;
            rr_ptr   <= rr_ptr_nx;
            idle_cnt <= idle_cnt_nx;
            cancel   <= cancel_nx;
            if (state == RESP) begin
                res_valid <= 1'b1;
                res_id    <= owner;
                res_drink <= core_drink;
                res_back  <= core_back;
                res_end   <= sess_end;
            end else begin
                res_valid <= 1'b0;
                res_id    <= '0;
                res_drink <= 1'b0;
                res_back  <= '0;
                res_end   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vend_session_arbiter.sv
// Bench for vend_session_arbiter: kiosk queues, a vending core model
// and a session-level reference model of expected results.
module tb_vend_session_arbiter;
    import vend_pkg::*;

    localparam int N       = 4;
    localparam int TIMEOUT = 16;
    localparam int W       = $clog2(N);

    typedef struct packed {
        logic [W-1:0] id;
        logic         drink;
        logic [1:0]   back;
        logic         fin;
    } res_t;
    typedef logic [1:0] coin_q_t[$];

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_valid;
    logic [2*N-1:0] req_coin;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   gnt;
    logic           res_valid;
    logic [W-1:0]   res_id;
    logic           res_drink;
    logic [1:0]     res_back;
    logic           res_end;
    logic [1:0]     core_coin;
    logic           core_drink;
    logic [1:0]     core_back;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_acc = 0;
    int bad_ready = 0;
    int bad_gnt = 0;
    int core_cr = 0;
    int mptr = 0;
    int gb = 0;

    coin_q_t      kq[N];
    coin_q_t      mq[N];
    res_t         got[$];
    res_t         exp_q[$];
    int           got_lat[$];
    logic [N-1:0] got_gnt[$];

    vend_session_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_coin   (req_coin),
        .req_ready  (req_ready),
        .gnt        (gnt),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_drink  (res_drink),
        .res_back   (res_back),
        .res_end    (res_end),
        .core_coin  (core_coin),
        .core_drink (core_drink),
        .core_back  (core_back)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Vending core: credit in units of 5, price PRICE_UNITS, result next cycle.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_cr = 0;
            core_drink <= 1'b0;
            core_back  <= 2'b00;
        end else begin
            core_drink <= 1'b0;
            core_back  <= 2'b00;
            if (core_coin == COIN_CANCEL) begin
                core_back <= 2'(core_cr);
                core_cr = 0;
            end else begin
                core_cr = core_cr + int'(core_coin);
                if (core_cr >= PRICE_UNITS) begin
                    core_drink <= 1'b1;
                    core_back  <= 2'(core_cr - PRICE_UNITS);
                    core_cr = 0;
                end
            end
        end
    end

    // Kiosk driver: head of each queue is presented until consumed.
    initial begin
        logic [N-1:0] take;
        req_valid = '0;
        req_coin  = '0;
        forever begin
            @(negedge clk);
            take = req_ready;
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (take[k] && kq[k].size() > 0) void'(kq[k].pop_front());
                req_valid[k] = (kq[k].size() > 0);
                req_coin[2*k +: 2] = (kq[k].size() > 0) ? kq[k][0] : 2'b00;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (res_valid) begin
            got.push_back(res_t'({res_id, res_drink, res_back, res_end}));
            got_lat.push_back(cyc - last_acc);
            got_gnt.push_back(gnt);
        end
        if (|req_ready) last_acc = cyc;
        if ((req_ready & ~gnt) != '0 || !$onehot0(req_ready)) bad_ready++;
        if (!$onehot0(gnt)) bad_gnt++;
    end

    function automatic res_t mk(int k, logic d, int b, logic f);
        return res_t'({W'(k), d, 2'(b), f});
    endfunction

    function automatic bit queues_empty();
        for (int k = 0; k < N; k++) begin
            if (kq[k].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic push_coin(int k, logic [1:0] c);
        kq[k].push_back(c);
        mq[k].push_back(c);
    endtask

    // Session-level model: whole sessions in round-robin order.
    task automatic model_run();
        int k;
        int j;
        int cr;
        bit done;
        logic [1:0] c;
        while (1) begin
            k = -1;
            for (int i = 0; i < N; i++) begin
                j = (mptr + i) % N;
                if (k < 0 && mq[j].size() > 0) k = j;
            end
            if (k < 0) break;
            cr = 0;
            done = 1'b0;
            while (!done) begin
                if (mq[k].size() == 0) begin
                    exp_q.push_back(mk(k, 1'b0, cr, 1'b1));
                    done = 1'b1;
                end else begin
                    c = mq[k].pop_front();
                    if (c == COIN_CANCEL) begin
                        exp_q.push_back(mk(k, 1'b0, cr, 1'b1));
                        done = 1'b1;
                    end else begin
                        cr += int'(c);
                        if (cr >= PRICE_UNITS) begin
                            exp_q.push_back(mk(k, 1'b1, cr - PRICE_UNITS, 1'b1));
                            done = 1'b1;
                        end else begin
                            exp_q.push_back(mk(k, 1'b0, 0, 1'b0));
                        end
                    end
                end
            end
            mptr = (k + 1) % N;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int k = 0; k < N; k++) begin
            kq[k].delete();
            mq[k].delete();
        end
        mptr = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        gb = got.size();
    endtask

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (queues_empty() && gnt == '0 && !res_valid) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({gnt, req_ready, core_coin} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%h exp=0", {gnt, req_ready, core_coin});
        end
        n_checks++;
        if ({res_valid, res_id, res_drink, res_back, res_end} !== '0) begin
            n_fail++;
            $display("FAIL reset_res got=%h exp=0",
                     {res_valid, res_id, res_drink, res_back, res_end});
        end
        do_reset();
        n_checks++;
        if ({gnt, req_ready, res_valid} !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset got=%h exp=0", {gnt, req_ready, res_valid});
        end
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        push_coin(0, COIN_10);
        push_coin(0, COIN_10);
        model_run();
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_early_gnt got=%b exp=0000", gnt);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({gnt, req_ready, core_coin} !== {4'b0001, 4'b0001, COIN_10}) begin
            n_fail++;
            $display("FAIL single_grant got=%b/%b/%b exp=0001/0001/10",
                     gnt, req_ready, core_coin);
        end
        drain(200, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_drain got=timeout exp=idle");
        end
        n_checks++;
        if (got.size() - gb != exp_q.size()) begin
            n_fail++;
            $display("FAIL single_count got=%0d exp=%0d", got.size() - gb, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got[gb+i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL single_res[%0d] got=%h exp=%h", i, got[gb+i], exp_q[i]);
                end
            end
            n_checks++;
            if (got[gb+1] !== mk(0, 1'b1, 0, 1'b1)) begin
                n_fail++;
                $display("FAIL single_drink got=%h exp=%h", got[gb+1], mk(0, 1'b1, 0, 1'b1));
            end
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (got_lat[gb+i] != 2) begin
                    n_fail++;
                    $display("FAIL single_latency[%0d] got=%0d exp=2", i, got_lat[gb+i]);
                end
            end
            n_checks++;
            if (got_gnt[gb+1] !== 4'b0000) begin
                n_fail++;
                $display("FAIL single_release got=%b exp=0000", got_gnt[gb+1]);
            end
        end
    endtask

    task automatic test_multi_coin();
        bit ok;
        do_reset();
        push_coin(2, COIN_5);
        push_coin(2, COIN_5);
        push_coin(2, COIN_5);
        push_coin(2, COIN_10);
        model_run();
        drain(200, ok);
        n_checks++;
        if (!ok || got.size() - gb != 4 || exp_q.size() != 4) begin
            n_fail++;
            $display("FAIL multi_count got=%0d exp=4 drained=%0d", got.size() - gb, ok);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (got[gb+i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL multi_res[%0d] got=%h exp=%h", i, got[gb+i], exp_q[i]);
                end
            end
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (got[gb+i].fin !== 1'b0) begin
                    n_fail++;
                    $display("FAIL multi_end[%0d] got=%b exp=0", i, got[gb+i].fin);
                end
            end
            n_checks++;
            if (got[gb+3] !== mk(2, 1'b1, 1, 1'b1)) begin
                n_fail++;
                $display("FAIL multi_drink got=%h exp=%h", got[gb+3], mk(2, 1'b1, 1, 1'b1));
            end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int ids[6] = '{1, 1, 3, 3, 1, 1};
        do_reset();
        for (int i = 0; i < 4; i++) push_coin(1, COIN_10);
        push_coin(3, COIN_10);
        push_coin(3, COIN_10);
        model_run();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL rr_first_gnt got=%b exp=0010", gnt);
        end
        drain(400, ok);
        n_checks++;
        if (!ok || got.size() - gb != 6 || exp_q.size() != 6) begin
            n_fail++;
            $display("FAIL rr_count got=%0d exp=6 drained=%0d", got.size() - gb, ok);
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (got[gb+i] !== exp_q[i] || int'(got[gb+i].id) != ids[i]) begin
                    n_fail++;
                    $display("FAIL rr_res[%0d] got=%h exp=%h id=%0d",
                             i, got[gb+i], exp_q[i], ids[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        bit found;
        int t11;
        logic [N-1:0] rdy;
        do_reset();
        push_coin(0, COIN_5);
        push_coin(0, COIN_10);
        model_run();
        found = 1'b0;
        t11 = 0;
        rdy = '0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (core_coin == COIN_CANCEL) begin
                found = 1'b1;
                t11 = cyc;
                rdy = req_ready;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL timeout_force got=none exp=coin 11");
        end else begin
            n_checks++;
            if (t11 - last_acc != TIMEOUT + 1) begin
                n_fail++;
                $display("FAIL timeout_cycle got=%0d exp=%0d", t11 - last_acc, TIMEOUT + 1);
            end
            n_checks++;
            if (rdy !== '0) begin
                n_fail++;
                $display("FAIL timeout_ready got=%b exp=0000", rdy);
            end
        end
        drain(200, ok);
        n_checks++;
        if (!ok || got.size() - gb != 3 || exp_q.size() != 3) begin
            n_fail++;
            $display("FAIL timeout_count got=%0d exp=3 drained=%0d", got.size() - gb, ok);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (got[gb+i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL timeout_res[%0d] got=%h exp=%h", i, got[gb+i], exp_q[i]);
                end
            end
            n_checks++;
            if (got[gb+2] !== mk(0, 1'b0, 3, 1'b1)) begin
                n_fail++;
                $display("FAIL timeout_refund got=%h exp=%h", got[gb+2], mk(0, 1'b0, 3, 1'b1));
            end
        end
    endtask

    task automatic test_cancel();
        bit ok;
        do_reset();
        push_coin(0, COIN_5);
        push_coin(0, COIN_CANCEL);
        model_run();
        drain(200, ok);
        n_checks++;
        if (!ok || got.size() - gb != 2 || exp_q.size() != 2) begin
            n_fail++;
            $display("FAIL cancel_count got=%0d exp=2 drained=%0d", got.size() - gb, ok);
        end else begin
            n_checks++;
            if (got[gb] !== exp_q[0] || got[gb+1] !== mk(0, 1'b0, 1, 1'b1)) begin
                n_fail++;
                $display("FAIL cancel_res got=%h,%h exp=%h,%h",
                         got[gb], got[gb+1], exp_q[0], mk(0, 1'b0, 1, 1'b1));
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        push_coin(0, COIN_10);
        for (int i = 0; i < 30 && got.size() == gb; i++) @(negedge clk);
        n_checks++;
        if (got.size() == gb) begin
            n_fail++;
            $display("FAIL midrst_first got=none exp=%h", mk(0, 1'b0, 0, 1'b0));
        end else if (got[gb] !== mk(0, 1'b0, 0, 1'b0) || gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL midrst_first got=%h gnt=%b exp=%h gnt=0001",
                     got[gb], gnt, mk(0, 1'b0, 0, 1'b0));
        end
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if ({gnt, req_ready, core_coin, res_valid, res_id, res_drink, res_back, res_end} !== '0) begin
            n_fail++;
            $display("FAIL midrst_async got=%h exp=0",
                     {gnt, req_ready, core_coin, res_valid, res_id, res_drink, res_back, res_end});
        end
        do_reset();
        push_coin(0, COIN_10);
        push_coin(0, COIN_5);
        push_coin(0, COIN_5);
        model_run();
        drain(200, ok);
        n_checks++;
        if (!ok || got.size() - gb != 3 || exp_q.size() != 3) begin
            n_fail++;
            $display("FAIL midrst_count got=%0d exp=3 drained=%0d", got.size() - gb, ok);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (got[gb+i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL midrst_res[%0d] got=%h exp=%h", i, got[gb+i], exp_q[i]);
                end
            end
            n_checks++;
            if (got[gb+1].drink !== 1'b0 || got[gb+2] !== mk(0, 1'b1, 0, 1'b1)) begin
                n_fail++;
                $display("FAIL midrst_credit got=%h,%h exp=drink only on third",
                         got[gb+1], got[gb+2]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int n;
        int r;
        logic [1:0] c;
        do_reset();
        for (int round = 0; round < 8; round++) begin
            gb = got.size();
            exp_q.delete();
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 9) < 7) begin
                    n = $urandom_range(1, 5);
                    for (int i = 0; i < n; i++) begin
                        r = $urandom_range(0, 9);
                        c = (r == 0) ? COIN_NONE : (r == 1) ? COIN_CANCEL :
                            (r < 6) ? COIN_5 : COIN_10;
                        push_coin(k, c);
                    end
                end
            end
            if (queues_empty()) push_coin($urandom_range(0, N - 1), COIN_10);
            model_run();
            drain(3000, ok);
            n_checks++;
            if (!ok || got.size() - gb != exp_q.size()) begin
                n_fail++;
                $display("FAIL rand%0d_count got=%0d exp=%0d drained=%0d",
                         round, got.size() - gb, exp_q.size(), ok);
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    n_checks++;
                    if (got[gb+i] !== exp_q[i]) begin
                        n_fail++;
                        $display("FAIL rand%0d_res[%0d] got=%h exp=%h",
                                 round, i, got[gb+i], exp_q[i]);
                    end
                end
            end
        end
        n_checks++;
        if (bad_ready != 0 || bad_gnt != 0) begin
            n_fail++;
            $display("FAIL onehot_owner got=%0d/%0d bad cycles exp=0/0", bad_ready, bad_gnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_coin();
        test_round_robin();
        test_timeout();
        test_cancel();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
